// File: rtl/mem_arbiter_if.sv
// picorv32-style memory bus: request fields flow master -> slave, ready/rdata flow back.
interface mem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, instr, addr, wdata, wstrb, input  ready, rdata);
  modport slave  (input  valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-master, one-slave arbiter for the picorv32 memory bus, one transaction in flight at a time,
// with a BUSY-cycle timeout so a dead slave cannot hang the core.
module mem_arbiter #(
  parameter bit          FIXED_PRIORITY = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic          owner,
  output logic          timeout_err
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic        last_owner;
  logic [15:0] count;

  logic any_req;
  logic winner;
  logic busy;
  logic timeout_hit;
  logic pass_rdata;
  logic done;

  // Grant decision and completion detection
  always_comb begin
    any_req = m0.valid | m1.valid;
    if (m0.valid && m1.valid)
      winner = FIXED_PRIORITY ? 1'b0 : ~last_owner;
    else
      winner = m1.valid;
    busy        = (state == BUSY) && !reset;
    timeout_hit = TO_EN && busy && !s.ready && (count == TO_LAST);
    pass_rdata  = busy && s.ready;
    done        = pass_rdata || timeout_hit;
  end

  // A timed-out transaction returns zero data to the owner
  assign m0.ready = done & ~owner;
  assign m1.ready = done &  owner;
  assign m0.rdata = (pass_rdata && !owner) ? s.rdata : 32'd0;
  assign m1.rdata = (pass_rdata &&  owner) ? s.rdata : 32'd0;

  // Request register towards memory
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      s.valid     <= 1'b0;
      s.instr     <= 1'b0;
      s.addr      <= 32'd0;
      s.wdata     <= 32'd0;
      s.wstrb     <= 4'd0;
      owner       <= 1'b0;
      timeout_err <= 1'b0;
      last_owner  <= 1'b1;
      count       <= 16'd0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            s.valid <= 1'b1;
            s.instr <= winner ? m1.instr : m0.instr;
            s.addr  <= winner ? m1.addr  : m0.addr;
            s.wdata <= winner ? m1.wdata : m0.wdata;
            s.wstrb <= winner ? m1.wstrb : m0.wstrb;
            owner   <= winner;
            count   <= 16'd0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            s.valid     <= 1'b0;
            last_owner  <= owner;
            timeout_err <= timeout_hit;
            state       <= IDLE;
          end else begin
            count <= count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: a round-robin instance (timeout 8) and a fixed-priority instance share one
// set of master/slave drivers, selected by sel.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sel;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_ready_drv;
  logic [31:0] s_rdata_drv;
  logic        own_r, own_f, terr_r, terr_f;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_last [2];

  typedef struct packed {
    bit own; bit instr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    logic [31:0] rdata; bit terr;
  } exp_t;

  typedef struct packed {
    bit seen; bit done; int wait_cyc; int busy_cyc; bit own; bit instr;
    logic [31:0] addr; logic [31:0] addr_end; logic [31:0] wdata; logic [3:0] wstrb;
    bit rdy0; bit rdy1; logic [31:0] rd0; logic [31:0] rd1; bit terr; bit sv_after;
  } obs_t;

  exp_t exp_q[$];

  mem_arbiter_if r0(), r1(), rs(), f0(), f1(), fs();

  assign r0.valid = m0_valid & ~sel;  assign f0.valid = m0_valid & sel;
  assign r1.valid = m1_valid & ~sel;  assign f1.valid = m1_valid & sel;
  assign r0.instr = m0_instr;  assign r0.addr = m0_addr;  assign r0.wdata = m0_wdata;  assign r0.wstrb = m0_wstrb;
  assign f0.instr = m0_instr;  assign f0.addr = m0_addr;  assign f0.wdata = m0_wdata;  assign f0.wstrb = m0_wstrb;
  assign r1.instr = m1_instr;  assign r1.addr = m1_addr;  assign r1.wdata = m1_wdata;  assign r1.wstrb = m1_wstrb;
  assign f1.instr = m1_instr;  assign f1.addr = m1_addr;  assign f1.wdata = m1_wdata;  assign f1.wstrb = m1_wstrb;
  assign rs.ready = s_ready_drv & ~sel;  assign rs.rdata = s_rdata_drv;
  assign fs.ready = s_ready_drv & sel;   assign fs.rdata = s_rdata_drv;

  wire        o_svalid = sel ? fs.valid : rs.valid;
  wire        o_sinstr = sel ? fs.instr : rs.instr;
  wire [31:0] o_saddr  = sel ? fs.addr  : rs.addr;
  wire [31:0] o_swdata = sel ? fs.wdata : rs.wdata;
  wire [3:0]  o_swstrb = sel ? fs.wstrb : rs.wstrb;
  wire        o_rdy0   = sel ? f0.ready : r0.ready;
  wire        o_rdy1   = sel ? f1.ready : r1.ready;
  wire [31:0] o_rd0    = sel ? f0.rdata : r0.rdata;
  wire [31:0] o_rd1    = sel ? f1.rdata : r1.rdata;
  wire        o_owner  = sel ? own_f : own_r;
  wire        o_terr   = sel ? terr_f : terr_r;

  mem_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(8)) dut_rr (
    .clk(clk), .reset(reset), .m0(r0), .m1(r1), .s(rs), .owner(own_r), .timeout_err(terr_r));
  mem_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(8)) dut_fp (
    .clk(clk), .reset(reset), .m0(f0), .m1(f1), .s(fs), .owner(own_f), .timeout_err(terr_f));

  // Scoreboard push: the arbitration rule applied to the requests currently driven
  task automatic expect_grant(input logic [31:0] rd, input bit terr);
    exp_t e;
    bit   w;
    if (m0_valid && m1_valid) w = sel ? 1'b0 : !model_last[sel];
    else                      w = m1_valid;
    e.own   = w;
    e.instr = w ? m1_instr : m0_instr;
    e.addr  = w ? m1_addr  : m0_addr;
    e.wdata = w ? m1_wdata : m0_wdata;
    e.wstrb = w ? m1_wstrb : m0_wstrb;
    e.rdata = terr ? 32'd0 : rd;
    e.terr  = terr;
    exp_q.push_back(e);
  endtask

  // Slave model: waits for s_valid, raises s_ready on BUSY cycle `delay`, records what it saw
  task automatic serve(input int delay, input logic [31:0] rd, output obs_t o);
    o = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_svalid) begin o.seen = 1'b1; o.wait_cyc = i; break; end
    end
    if (!o.seen) return;
    o.own = o_owner; o.instr = o_sinstr; o.addr = o_saddr; o.wdata = o_swdata; o.wstrb = o_swstrb;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) @(negedge clk);
      if (c == delay) begin s_rdata_drv = rd; s_ready_drv = 1'b1; end
      #1;
      if (o_rdy0 || o_rdy1) begin
        o.done = 1'b1; o.busy_cyc = c; o.rdy0 = o_rdy0; o.rdy1 = o_rdy1;
        o.rd0 = o_rd0; o.rd1 = o_rd1; o.addr_end = o_saddr;
        break;
      end
    end
    @(posedge clk); #1;
    s_ready_drv = 1'b0; s_rdata_drv = 32'd0;
    o.terr = o_terr; o.sv_after = o_svalid;
    if (o.rdy0) m0_valid = 1'b0;
    if (o.rdy1) m1_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sel = 1'b0; s_ready_drv = 1'b0; s_rdata_drv = 32'd0;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    model_last[0] = 1'b1; model_last[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (o_svalid !== 1'b0) begin n_bad++; $display("FAIL rst_svalid got %b want 0", o_svalid); end
    n_cmp++; if (o_saddr !== 32'd0) begin n_bad++; $display("FAIL rst_saddr got %h want 0", o_saddr); end
    n_cmp++; if (o_swstrb !== 4'd0) begin n_bad++; $display("FAIL rst_swstrb got %h want 0", o_swstrb); end
    n_cmp++; if (o_owner !== 1'b0) begin n_bad++; $display("FAIL rst_owner got %b want 0", o_owner); end
    n_cmp++; if (o_terr !== 1'b0) begin n_bad++; $display("FAIL rst_terr got %b want 0", o_terr); end
    n_cmp++; if ({o_rdy1, o_rdy0} !== 2'b00) begin n_bad++; $display("FAIL rst_ready got %b want 00", {o_rdy1, o_rdy0}); end
    @(posedge clk); #1 reset = 1'b0;
    s_ready_drv = 1'b1;
    @(negedge clk);
    n_cmp++; if ({o_rdy1, o_rdy0} !== 2'b00) begin n_bad++; $display("FAIL idle_sready_ready got %b want 00", {o_rdy1, o_rdy0}); end
    @(posedge clk); #1 s_ready_drv = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_svalid !== 1'b0) begin n_bad++; $display("FAIL idle_sready_svalid got %b want 0", o_svalid); end
  endtask

  task automatic test_rr_tie();
    obs_t o; exp_t e; logic [3:0] owners;
    owners = 4'd0;
    @(posedge clk); #1;
    sel = 1'b0;
    m0_addr = 32'h1000; m1_addr = 32'h2000; m0_wstrb = 0; m1_wstrb = 0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_grant(32'h100 + k, 1'b0);
      serve(k % 2, 32'h100 + k, o);
      e = exp_q.pop_front();
      model_last[0] = e.own;
      owners[k] = o.own;
      n_cmp++; if (o.own !== e.own) begin n_bad++; $display("FAIL rr_owner%0d got %b want %b", k, o.own, e.own); end
      n_cmp++; if (o.addr !== e.addr) begin n_bad++; $display("FAIL rr_addr%0d got %h want %h", k, o.addr, e.addr); end
      n_cmp++; if (o.wait_cyc !== 1) begin n_bad++; $display("FAIL rr_latency%0d got %0d want 1", k, o.wait_cyc); end
      n_cmp++; if ({o.rdy1, o.rdy0} !== (e.own ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_ready%0d got %b want %b", k, {o.rdy1, o.rdy0}, e.own ? 2'b10 : 2'b01); end
      n_cmp++; if ((e.own ? o.rd1 : o.rd0) !== e.rdata) begin n_bad++; $display("FAIL rr_rdata%0d got %h want %h", k, e.own ? o.rd1 : o.rd0, e.rdata); end
      if (k < 2) begin
        if (e.own) begin m1_valid = 1'b1; m1_addr = m1_addr + 4; end
        else       begin m0_valid = 1'b1; m0_addr = m0_addr + 4; end
      end
    end
    n_cmp++; if (owners !== 4'b1010) begin n_bad++; $display("FAIL rr_sequence got %b want 1010", owners); end
  endtask

  task automatic test_fixed_priority();
    obs_t o; exp_t e; logic [3:0] owners;
    owners = 4'd0;
    @(posedge clk); #1;
    sel = 1'b1;
    m0_addr = 32'h3000; m1_addr = 32'h4000;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_grant(32'h200 + k, 1'b0);
      serve(1, 32'h200 + k, o);
      e = exp_q.pop_front();
      owners[k] = o.own;
      n_cmp++; if (o.own !== e.own) begin n_bad++; $display("FAIL fp_owner%0d got %b want %b", k, o.own, e.own); end
      n_cmp++; if (o.addr !== e.addr) begin n_bad++; $display("FAIL fp_addr%0d got %h want %h", k, o.addr, e.addr); end
      if (k < 2 && !e.own) begin m0_valid = 1'b1; m0_addr = m0_addr + 4; end
    end
    n_cmp++; if (owners !== 4'b1000) begin n_bad++; $display("FAIL fp_sequence got %b want 1000", owners); end
    m0_valid = 1'b0; m1_valid = 1'b0;
    sel = 1'b0;
  endtask

  task automatic test_single_read();
    obs_t o; exp_t e;
    @(posedge clk); #1;
    m0_instr = 1'b0; m0_addr = 32'h100; m0_wdata = 32'd0; m0_wstrb = 4'd0; m0_valid = 1'b1;
    expect_grant(32'hDEADBEEF, 1'b0);
    serve(3, 32'hDEADBEEF, o);
    e = exp_q.pop_front();
    model_last[0] = e.own;
    n_cmp++; if (o.seen !== 1'b1) begin n_bad++; $display("FAIL rd_granted got %b want 1", o.seen); end
    n_cmp++; if (o.wait_cyc !== 1) begin n_bad++; $display("FAIL rd_latency got %0d want 1", o.wait_cyc); end
    n_cmp++; if (o.own !== e.own) begin n_bad++; $display("FAIL rd_owner got %b want %b", o.own, e.own); end
    n_cmp++; if (o.addr !== e.addr) begin n_bad++; $display("FAIL rd_saddr got %h want %h", o.addr, e.addr); end
    n_cmp++; if (o.wstrb !== e.wstrb) begin n_bad++; $display("FAIL rd_swstrb got %h want %h", o.wstrb, e.wstrb); end
    n_cmp++; if (o.busy_cyc !== 3) begin n_bad++; $display("FAIL rd_ready_cycle got %0d want 3", o.busy_cyc); end
    n_cmp++; if ({o.rdy1, o.rdy0} !== 2'b01) begin n_bad++; $display("FAIL rd_ready got %b want 01", {o.rdy1, o.rdy0}); end
    n_cmp++; if (o.rd0 !== e.rdata) begin n_bad++; $display("FAIL rd_rdata got %h want %h", o.rd0, e.rdata); end
    n_cmp++; if (o.rd1 !== 32'd0) begin n_bad++; $display("FAIL rd_m1_rdata got %h want 0", o.rd1); end
    n_cmp++; if (o.terr !== e.terr) begin n_bad++; $display("FAIL rd_terr got %b want %b", o.terr, e.terr); end
    n_cmp++; if (o.sv_after !== 1'b0) begin n_bad++; $display("FAIL rd_svalid_drop got %b want 0", o.sv_after); end
    @(negedge clk);
    n_cmp++; if ({o_rdy1, o_rdy0} !== 2'b00) begin n_bad++; $display("FAIL rd_ready_one_cycle got %b want 00", {o_rdy1, o_rdy0}); end
  endtask

  task automatic test_write();
    obs_t o; exp_t e;
    @(posedge clk); #1;
    m1_instr = 1'b0; m1_addr = 32'h204; m1_wdata = 32'h12345678; m1_wstrb = 4'b1100; m1_valid = 1'b1;
    expect_grant(32'h000000AA, 1'b0);
    fork
      serve(2, 32'h000000AA, o);
      begin repeat (2) @(negedge clk); #2 m1_addr = 32'hFFFF0000; end
    join
    e = exp_q.pop_front();
    model_last[0] = e.own;
    n_cmp++; if (o.own !== e.own) begin n_bad++; $display("FAIL wr_owner got %b want %b", o.own, e.own); end
    n_cmp++; if (o.addr !== e.addr) begin n_bad++; $display("FAIL wr_saddr got %h want %h", o.addr, e.addr); end
    n_cmp++; if (o.addr_end !== e.addr) begin n_bad++; $display("FAIL wr_saddr_frozen got %h want %h", o.addr_end, e.addr); end
    n_cmp++; if (o.wdata !== e.wdata) begin n_bad++; $display("FAIL wr_swdata got %h want %h", o.wdata, e.wdata); end
    n_cmp++; if (o.wstrb !== e.wstrb) begin n_bad++; $display("FAIL wr_swstrb got %b want %b", o.wstrb, e.wstrb); end
    n_cmp++; if (o.instr !== e.instr) begin n_bad++; $display("FAIL wr_sinstr got %b want %b", o.instr, e.instr); end
    n_cmp++; if ({o.rdy1, o.rdy0} !== 2'b10) begin n_bad++; $display("FAIL wr_ready got %b want 10", {o.rdy1, o.rdy0}); end
    n_cmp++; if (o.rd1 !== e.rdata) begin n_bad++; $display("FAIL wr_rdata got %h want %h", o.rd1, e.rdata); end
    n_cmp++; if (o.rd0 !== 32'd0) begin n_bad++; $display("FAIL wr_m0_rdata got %h want 0", o.rd0); end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    @(posedge clk); #1;
    m0_instr = 1'b1; m0_addr = 32'h300; m0_wstrb = 4'd0; m0_valid = 1'b1;
    expect_grant(32'h55555555, 1'b1);
    serve(100, 32'h55555555, o);
    e = exp_q.pop_front();
    model_last[0] = e.own;
    n_cmp++; if (o.instr !== e.instr) begin n_bad++; $display("FAIL to_sinstr got %b want %b", o.instr, e.instr); end
    n_cmp++; if (o.busy_cyc !== 7) begin n_bad++; $display("FAIL to_ready_cycle got %0d want 7", o.busy_cyc); end
    n_cmp++; if ({o.rdy1, o.rdy0} !== 2'b01) begin n_bad++; $display("FAIL to_ready got %b want 01", {o.rdy1, o.rdy0}); end
    n_cmp++; if (o.rd0 !== e.rdata) begin n_bad++; $display("FAIL to_rdata got %h want %h", o.rd0, e.rdata); end
    n_cmp++; if (o.terr !== e.terr) begin n_bad++; $display("FAIL to_terr got %b want %b", o.terr, e.terr); end
    n_cmp++; if (o.sv_after !== 1'b0) begin n_bad++; $display("FAIL to_svalid_drop got %b want 0", o.sv_after); end
    @(posedge clk); #1;
    n_cmp++; if (o_terr !== 1'b0) begin n_bad++; $display("FAIL to_terr_pulse got %b want 0", o_terr); end
    m1_instr = 1'b0; m1_addr = 32'h600; m1_wstrb = 4'd0; m1_valid = 1'b1;
    expect_grant(32'hCAFEF00D, 1'b0);
    serve(1, 32'hCAFEF00D, o);
    e = exp_q.pop_front();
    model_last[0] = e.own;
    n_cmp++; if (o.own !== e.own) begin n_bad++; $display("FAIL to_next_owner got %b want %b", o.own, e.own); end
    n_cmp++; if (o.rd1 !== e.rdata) begin n_bad++; $display("FAIL to_next_rdata got %h want %h", o.rd1, e.rdata); end
    n_cmp++; if (o.terr !== e.terr) begin n_bad++; $display("FAIL to_next_terr got %b want %b", o.terr, e.terr); end
    m0_instr = 1'b0; m0_addr = 32'h304; m0_valid = 1'b1;
    expect_grant(32'h00000077, 1'b0);
    serve(7, 32'h00000077, o);
    e = exp_q.pop_front();
    model_last[0] = e.own;
    n_cmp++; if (o.busy_cyc !== 7) begin n_bad++; $display("FAIL to_race_cycle got %0d want 7", o.busy_cyc); end
    n_cmp++; if (o.rd0 !== e.rdata) begin n_bad++; $display("FAIL to_race_rdata got %h want %h", o.rd0, e.rdata); end
    n_cmp++; if (o.terr !== e.terr) begin n_bad++; $display("FAIL to_race_terr got %b want %b", o.terr, e.terr); end
  endtask

  task automatic test_reset_busy();
    obs_t o; exp_t e;
    @(posedge clk); #1;
    m0_addr = 32'h400; m0_valid = 1'b1;
    expect_grant(32'h1, 1'b0);
    serve(0, 32'h1, o);
    e = exp_q.pop_front();
    model_last[0] = e.own;
    m1_addr = 32'h500; m1_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({o_svalid, o_owner} !== 2'b11) begin n_bad++; $display("FAIL rb_busy got %b want 11", {o_svalid, o_owner}); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({o_rdy1, o_rdy0} !== 2'b00) begin n_bad++; $display("FAIL rb_ready_in_reset got %b want 00", {o_rdy1, o_rdy0}); end
    @(negedge clk);
    n_cmp++; if (o_svalid !== 1'b0) begin n_bad++; $display("FAIL rb_svalid got %b want 0", o_svalid); end
    n_cmp++; if (o_owner !== 1'b0) begin n_bad++; $display("FAIL rb_owner got %b want 0", o_owner); end
    n_cmp++; if ({o_rdy1, o_rdy0} !== 2'b00) begin n_bad++; $display("FAIL rb_ready got %b want 00", {o_rdy1, o_rdy0}); end
    reset = 1'b0;
    model_last[0] = 1'b1; model_last[1] = 1'b1;
    m0_addr = 32'h700; m0_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      expect_grant(32'h900 + k, 1'b0);
      serve(1, 32'h900 + k, o);
      e = exp_q.pop_front();
      model_last[0] = e.own;
      n_cmp++; if (o.own !== e.own) begin n_bad++; $display("FAIL rb_tie_owner%0d got %b want %b", k, o.own, e.own); end
      n_cmp++; if (o.own !== k[0]) begin n_bad++; $display("FAIL rb_tie_order%0d got %b want %b", k, o.own, k[0]); end
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_rr_tie();
    test_fixed_priority();
    test_single_read();
    test_write();
    test_timeout();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
